// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and constants for the APB initiator.
// State encoding, default bus widths and the timeout counter width live here
// so the top and the timeout counter agree on them.
package apb_master_pkg;

    // Default APB address and data widths
    localparam int APB_ADDR_W_DEF = 32;
    localparam int APB_DATA_W_DEF = 32;

    // Width of the ACCESS-phase timeout counter (limits up to 255)
    localparam int TO_CNT_W = 8;

    // Initiator FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apbState_t;

    // True for the two states in which the bus is selected
    function automatic logic isBusPhase(input apbState_t st);
        return (st == SETUP) || (st == ACCESS);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles in which the responder holds pReady
// low and flags the edge on which the count reaches LIMIT.
// Only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic limitHit
);

    logic [TO_CNT_W-1:0] count;

    // Count wait cycles; cleared on reset and on entry to ACCESS
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    // Limit is reached when this increment brings the count to LIMIT
    always_comb begin
        limitHit = incr && (count == TO_CNT_W'(LIMIT - 1));
    end

endmodule
`endif

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator. Converts a valid/ready
// command stream into SETUP/ACCESS bus transactions and returns read data or
// completion status on a valid/ready response stream.
// Optional feature macro: APB_TIMEOUT_EN (forced termination of long ACCESS).
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both 1; the producer holds valid and its payload stable
// until that edge, and ready never depends combinationally on valid.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W_DEF,
    parameter int DATA_W         = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic              pReady,
    input  logic [DATA_W-1:0] pReadData
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
    end

    apbState_t state;
    apbState_t stateNext;
    logic      cmdFire;
    logic      accessDone;
    logic      timedOut;
    logic      limitHit;

`ifdef APB_TIMEOUT_EN
    // Wait-cycle counter: cleared while in SETUP, counts ACCESS cycles with pReady low
    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uTimeoutCnt (
        .clk      (pClk),
        .rst      (pReset),
        .clear    (state == SETUP),
        .incr     ((state == ACCESS) && !pReady),
        .limitHit (limitHit)
    );
`else
    assign limitHit = 1'b0;
`endif

    // Command is accepted only from IDLE and never while reset is asserted
    assign cmd_ready = (state == IDLE) && !pReset;
    assign cmdFire   = cmd_valid && cmd_ready;

    // Next-state decode; pReady matters only in ACCESS, and wins over the limit
    always_comb begin
        stateNext  = state;
        accessDone = 1'b0;
        timedOut   = 1'b0;
        case (state)
            IDLE: begin
                if (cmdFire) begin
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                stateNext = ACCESS;
            end
            ACCESS: begin
                if (pReady) begin
                    stateNext  = RESP;
                    accessDone = 1'b1;
                end else if (limitHit) begin
                    stateNext = RESP;
                    timedOut  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Bus outputs: phase strobes follow the next state, payload latched on accept
    always_ff @(posedge pClk) begin
        if (pReset) begin
            pSel    <= 1'b0;
            pEnable <= 1'b0;
            pWrite  <= 1'b0;
            pAddr   <= '0;
            pWdata  <= '0;
        end else begin
            pSel    <= isBusPhase(stateNext);
            pEnable <= (stateNext == ACCESS);
            if (cmdFire) begin
                pWrite <= cmd_write;
                pAddr  <= cmd_addr;
                pWdata <= cmd_wdata;
            end
        end
    end

    // Response valid and read data; data only changes when an ACCESS ends
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (stateNext == RESP);
            if (accessDone) begin
                rsp_rdata <= pWrite ? '0 : pReadData;
            end else if (timedOut) begin
                rsp_rdata <= '0;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    // Error flag: set by a forced termination, cleared by a normal completion
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rsp_err <= 1'b0;
        end else if (accessDone) begin
            rsp_err <= 1'b0;
        end else if (timedOut) begin
            rsp_err <= 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
